mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: ADDR_W, default 22, data-memory word-address width taken from EX_ALU_result[ADDR_W-1:0].
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, WAIT cycles without ack before abort; used only when MEM_TIMEOUT_EN is defined.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  kill current instruction's result.
REQ-006 hlt  in  1  processor halt; blocks new accesses.
REQ-007 EX_mem_re  in  1  current instruction is a load.
REQ-008 EX_mem_we  in  1  current instruction is a store.
REQ-009 EX_ALU_result  in  32  computed address or ALU value.
REQ-010 EX_store_data  in  32  store write data.
REQ-011 dmem_req  out  1  registered memory request, held until ack.
REQ-012 dmem_we  out  1  registered write enable, valid with dmem_req.
REQ-013 dmem_addr  out  ADDR_W  registered word address.
REQ-014 dmem_wdata  out  32  registered write data.
REQ-015 dmem_ack  in  1  one-cycle completion pulse from memory.
REQ-016 dmem_rdata  in  32  read data, valid when dmem_ack=1.
REQ-017 mem_stall  out  1  upstream and EX/MEM register must hold.
REQ-018 MEM_ALU_result  out  32  result presented to MEM/WB register.
REQ-019 MEM_mem_ALU_select  out  1  1 = result is load data.
REQ-020 mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; constant 0 otherwise).

Function
REQ-021 FSM states IDLE, WAIT, RESP; no other states reachable.
REQ-022 IDLE, access = (EX_mem_re|EX_mem_we) & !flush & !hlt: latch address, wdata, we (we=EX_mem_we; re wins nothing, we=1 only if EX_mem_we); go WAIT; mem_stall=1 combinationally in this cycle.
REQ-023 IDLE, no access: MEM_ALU_result=EX_ALU_result, MEM_mem_ALU_select=0, mem_stall=0, zero-latency pass-through.
REQ-024 WAIT: dmem_req=1, mem_stall=1; dmem_ack sampled only here; on ack capture dmem_rdata (loads) and go RESP.
REQ-025 Earliest ack: first WAIT cycle; minimum access occupies IDLE+WAIT+RESP = 3 cycles.
REQ-026 RESP: dmem_req=0, mem_stall=0; load -> MEM_ALU_result=captured rdata, select=1; store -> MEM_ALU_result=EX_ALU_result, select=0; next state IDLE unconditionally.
REQ-027 RESP never issues a new access even though EX inputs still hold the same instruction.
REQ-028 flush during WAIT does not abort the bus transaction; sets drop flag; RESP then drives MEM_ALU_result=0, select=0.
REQ-029 flush during RESP: outputs forced to 0, select=0; drop flag cleared on entering IDLE.
REQ-030 hlt asserted in WAIT/RESP: in-flight access completes normally; hlt only gates IDLE->WAIT.
REQ-031 Simultaneous EX_mem_re and EX_mem_we: treated as store.
REQ-032 dmem_ack outside WAIT is ignored.

Reset
REQ-033 rst_n low: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, captured data=0, drop flag=0, timeout counter=0, mem_err=0.
REQ-034 Reset mid-WAIT drops dmem_req immediately (asynchronously); late ack after reset ignored.

Configuration
REQ-035 Macro MEM_TIMEOUT_EN defined: counter increments each WAIT cycle without ack; on reaching TIMEOUT_CYCLES, drop dmem_req, go RESP with MEM_ALU_result=0, select=0, set mem_err=1 until reset; counter clears on leaving WAIT.
REQ-036 MEM_TIMEOUT_EN undefined: no counter, WAIT lasts until ack indefinitely, mem_err tied 0.

Verification
REQ-037 No access, EX_ALU_result=32'h0000_1234 -> same cycle MEM_ALU_result=32'h0000_1234, select=0, mem_stall=0.
REQ-038 Load addr 22'h00_0040, ack after 3 WAIT cycles with rdata=32'hCAFE_F00D -> stall 4 cycles, RESP result=32'hCAFE_F00D, select=1, dmem_req high exactly 3 cycles.
REQ-039 Store addr 22'h00_0010, data 32'hA5A5_A5A5, ack in first WAIT -> dmem_we=1, dmem_wdata=32'hA5A5_A5A5, stall 2 cycles, RESP select=0.
REQ-040 Load, flush in second WAIT cycle, ack next cycle -> transaction completes, RESP result=0, select=0, next instruction accepted.
REQ-041 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 WAIT cycles, mem_err=1 and stays 1, result=0.
REQ-042 Reset asserted in WAIT, ack one cycle later -> dmem_req=0 immediately, state IDLE, no result produced.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a registered req/ack data-memory port.
// Latency: non-memory ops pass through with zero latency; a load/store takes >= 3 cycles (IDLE+WAIT+RESP).
// Backpressure: mem_stall holds upstream from the accepting cycle through WAIT; dmem_req held until dmem_ack.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES without ack (sticky mem_err).
module mem_access_stage #(
   parameter int ADDR_W         = 22,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              hlt,
   input  logic              EX_mem_re,
   input  logic              EX_mem_we,
   input  logic [31:0]       EX_ALU_result,
   input  logic [31:0]       EX_store_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              mem_stall,
   output logic [31:0]       MEM_ALU_result,
   output logic              MEM_mem_ALU_select,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                access;
   logic                timeout_w;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                drop_q, drop_d;

   // A new access is only started from IDLE, and never for a killed or halted instruction.
   assign access = (EX_mem_re | EX_mem_we) & ~flush & ~hlt;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Abort on the WAIT cycle that would be the TIMEOUT_CYCLES-th without an ack.
   assign timeout_w = (state_q == S_WAIT) && !dmem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count ack-less WAIT cycles; counter is zero whenever we are not waiting; error is sticky.
   always_comb begin
      cnt_d = '0;
      err_d = err_q | timeout_w;
      if ((state_q == S_WAIT) && !dmem_ack && !timeout_w) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Timeout counter and sticky error register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;
`else
   // The timeout length only matters when the timeout feature is compiled in.
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_w = 1'b0;
   assign mem_err   = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: RESP always returns to IDLE so the held EX instruction is not reissued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (access) state_d = S_WAIT;
         S_WAIT:  if (dmem_ack || timeout_w) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: latch the request on accept, capture load data on ack, track drops.
   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               req_d   = 1'b1;
               we_d    = EX_mem_we;
               addr_d  = EX_ALU_result[ADDR_W-1:0];
               wdata_d = EX_store_data;
            end
         end
         S_WAIT: begin
            // A flush cannot cancel a bus transaction already in flight; remember to discard it.
            if (flush) drop_d = 1'b1;
            if (dmem_ack) begin
               req_d = 1'b0;
               if (!we_q) rdata_d = dmem_rdata;
            end else if (timeout_w) begin
               req_d  = 1'b0;
               drop_d = 1'b1;
            end
         end
         S_RESP: begin
            drop_d = 1'b0;
         end
         default: begin
            req_d  = 1'b0;
            drop_d = 1'b0;
         end
      endcase
   end

   // Datapath registers; async reset drops an in-flight request immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         drop_q  <= drop_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;

   // FSM outputs: stall and the result handed to MEM/WB.
   always_comb begin
      mem_stall          = 1'b0;
      MEM_ALU_result     = EX_ALU_result;
      MEM_mem_ALU_select = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_stall = access;
         end
         S_WAIT: begin
            mem_stall      = 1'b1;
            MEM_ALU_result = '0;
         end
         S_RESP: begin
            if (flush || drop_q) begin
               MEM_ALU_result = '0;
            end else if (!we_q) begin
               MEM_ALU_result     = rdata_q;
               MEM_mem_ALU_select = 1'b1;
            end
         end
         default: begin
            MEM_ALU_result = '0;
         end
      endcase
   end

endmodule
